store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH SHALL default to 4 and set the number of buffered stores (power of 2, >= 2).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port st_valid  input  1  store request from the partial-store stage.
REQ-006 Port st_addr  input  32  store byte address; only bits [31:2] are stored.
REQ-007 Port st_data  input  32  lane-aligned store data.
REQ-008 Port st_mask  input  4  byte write mask.
REQ-009 Port st_ready  output  1  buffer can accept a store.
REQ-010 Port ld_valid  input  1  load address is being checked this cycle.
REQ-011 Port ld_addr  input  32  load byte address.
REQ-012 Port ld_hazard  output  1  load word matches a pending store.
REQ-013 Port mem_wvalid  output  1  head entry is presented to memory.
REQ-014 Port mem_waddr  output  32  head word address, with bits [1:0] = 0.
REQ-015 Port mem_wdata  output  32  head data.
REQ-016 Port mem_wmask  output  4  head byte mask.
REQ-017 Port mem_wready  input  1  memory accepts the head this cycle.
REQ-018 Port count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-019 The buffer SHALL be a FIFO with read and write pointers that wrap modulo DEPTH.
REQ-020 Push SHALL occur on a clock edge when st_valid && st_ready && st_mask != 0.
REQ-021 A request with st_mask == 0 SHALL be dropped: no push, no change to count or st_ready.
REQ-022 st_ready SHALL be 1 exactly when count < DEPTH.
  - Full refuses a push even if a pop occurs in the same cycle.
  - There is no full bypass.
REQ-023 Pop SHALL occur on a clock edge when mem_wvalid && mem_wready.
REQ-024 mem_wvalid SHALL be 1 exactly when count != 0.
  - mem_waddr, mem_wdata and mem_wmask SHALL drive the head entry.
  - They SHALL drive 0 when the buffer is empty.
REQ-025 There SHALL be no empty bypass: a store pushed at edge N is first visible on mem_w* after edge N.
REQ-026 The head outputs SHALL stay stable while mem_wvalid && !mem_wready.
REQ-027 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-028 mem_wready while empty SHALL be ignored.
REQ-029 ld_hazard SHALL be combinational and equal to ld_valid && (any valid entry has addr[31:2] == ld_addr[31:2]).
  - The head SHALL be included even if it pops this cycle.
  - A store being pushed in the same cycle SHALL be excluded.
REQ-030 Mask values SHALL be stored unmodified; the block SHALL NOT merge entries.

Reset
REQ-031 While rst_n = 0, the block SHALL hold count = 0, pointers = 0, st_ready = 1, mem_wvalid = 0, mem_waddr/mem_wdata/mem_wmask = 0 and ld_hazard = 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-033 The first push SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-034 Single store: push addr 0x00000102, data 0x56780000, mask 4'b1100 with mem_wready = 0 -> next cycle mem_wvalid = 1, mem_waddr = 0x00000100, mem_wdata = 0x56780000, mem_wmask = 4'b1100, count = 1; raise mem_wready -> following cycle count = 0, mem_wvalid = 0.
REQ-035 Fill/full: push 4 stores (addr 0x0, 0x4, 0x8, 0xC) with mem_wready = 0 -> count = 4, st_ready = 0; a 5th push with mem_wready = 1 is refused; drain order is 0x0, 0x4, 0x8, 0xC.
REQ-036 Simultaneous push/pop at count = 2 -> count stays 2; pointers wrap after 6 total pushes without data corruption.
REQ-037 Hazard: pending store at 0x20 -> ld_addr 0x23 gives ld_hazard = 1; ld_addr 0x24 gives 0; ld_valid = 0 gives 0; a push to 0x24 in the same cycle as a check of 0x24 gives 0.
REQ-038 Zero mask and reset: st_valid with st_mask = 0 -> count unchanged; rst_n pulsed low for 3 ns with 3 entries queued -> count = 0 and mem_wvalid = 0 before the next clock edge.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer between the partial-store stage and memory
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   st_valid/st_addr/st_data/st_mask/st_ready
//                      store push interface; requests with an all-zero mask are dropped
//   ld_valid/ld_addr/ld_hazard
//                      word-granular load check against all pending stores (combinational)
//   mem_wvalid/mem_waddr/mem_wdata/mem_wmask/mem_wready
//                      head-of-queue write toward memory; zeros when empty
//   count              number of occupied entries
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [3:0]                 st_mask,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hazard,
    output logic                       mem_wvalid,
    output logic [31:0]                mem_waddr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_wmask,
    input  logic                       mem_wready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       mask_q [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             push;
    logic             pop;
    logic             addr_hit;

    // Byte-offset bits never matter: entries and hazard checks are word-granular.
    logic             unused_offset;
    assign unused_offset = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready   = (count_q < CW'(DEPTH));
    assign mem_wvalid = (count_q != '0);
    assign count      = count_q;

    // A zero mask never occupies an entry; a full buffer refuses even when popping.
    assign push = st_valid && st_ready && (st_mask != 4'b0000);
    assign pop  = mem_wvalid && mem_wready;

    always_comb begin
        mem_waddr = 32'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        if (mem_wvalid) begin
            mem_waddr = {addr_q[rd_ptr_q], 2'b00};
            mem_wdata = data_q[rd_ptr_q];
            mem_wmask = mask_q[rd_ptr_q];
        end
    end

    // Only registered entries are compared, so a store arriving this cycle is
    // never seen, while the head stays visible even if it leaves this cycle.
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[31:2])) begin
                addr_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid && addr_hit;

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // push and pop never target the same slot: pop needs count > 0 and
        // push needs count < DEPTH, so the two pointers differ when both fire.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: every read of it is qualified by valid/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr[31:2];
            data_q[wr_ptr_q] <= st_data;
            mask_q[wr_ptr_q] <= st_mask;
        end
    end

endmodule
